mem_arbiter4: RTL
=================

# mem_arbiter4

Four-port round-robin arbiter that shares the single Hack RAM port among up to four requesters (CPU data port, boot loader, screen scanout, keyboard/IO DMA). Each cycle it grants at most one requester and drives that requester's address, write data and write enable onto the memory port. It returns read data one cycle later with a per-port valid strobe. An optional lock gives a requester short back-to-back bursts, capped by a burst counter so no port starves.

## Interface
Parameters:
- `AW`, 15: address width (Hack 32K word space)
- `DW`, 16: data width
- `MAX_BURST`, 4: maximum consecutive grants under lock (range 1–15)

Ports (`N_REQ` = 4, fixed):
- `clk`, in, 1: clock; all state updates on its rising edge
- `rst_n`, in, 1: synchronous reset, active-low, sampled on the rising edge of `clk`
- `req`, in, 4: per-port request; held high until granted
- `lock`, in, 4: per-port burst hint; qualified only by `req`
- `we`, in, 4: per-port write enable
- `addr_i`, in, 4*AW: port i address at bits [i*AW +: AW]
- `wdata_i`, in, 4*DW: port i write data at bits [i*DW +: DW]
- `gnt`, out, 4: one-hot or zero, combinational; `gnt[i]` means port i's command is on the memory port this cycle and is consumed at the next edge
- `rvalid`, out, 4: registered; one-hot or zero
- `rdata`, out, DW: read data; meaningful only while some `rvalid` bit is high
- `mem_addr`, out, AW: memory port address (combinational from the granted port)
- `mem_wdata`, out, DW: memory port write data (combinational from the granted port)
- `mem_we`, out, 1: memory write strobe; equals `we[g] & gnt[g]`
- `mem_rdata`, in, DW: memory read data; the synchronous RAM returns it one cycle after the address

## Operation
State registers:
- `ptr` (2b): round-robin start index
- `owner` (2b) plus `owned` flag
- `bcnt` (4b): grants issued in the current burst
- `rv_q` (4b): read-valid pipeline

Grant selection, each cycle:
- If `owned` and `req[owner]`: grant `owner`.
- Otherwise: grant the first i with `req[i]`=1, searching ptr, ptr+1, … mod 4.
- No requests: `gnt`=0, `mem_we`=0, `mem_addr`/`mem_wdata` hold port `ptr`'s inputs (don't-care).

Update at each edge, when port g is granted:
- Continue the burst if `lock[g]`=1 and `bcnt`+1 < MAX_BURST: `owned`=1, `owner`=g, `bcnt`+=1, `ptr` unchanged.
- Otherwise: `owned`=0, `bcnt`=0, `ptr`=g+1 mod 4. This applies both to a non-lock grant and to the grant that reaches MAX_BURST.
- If the owner drops `req`, `owned` clears that edge with no grant charged to it. Normal round-robin from `ptr` applies in that same cycle.

Read return:
- `rv_q[g]` ← `gnt[g] & ~we[g]`; all other bits ← 0.
- `rvalid` = `rv_q`; `rdata` = `mem_rdata`, passed through unregistered because the memory already registers.

Writes produce no `rvalid`.

Lock with MAX_BURST=1 behaves as pure round-robin.

## Timing
- Reset values (`rst_n`=0 at an edge): `ptr`=0, `owned`=0, `bcnt`=0, `rvalid`=0. During reset `gnt` is forced to 0, so `mem_we`=0.
- Grant latency: 0 cycles. A request asserted in cycle t with no contention is granted in cycle t.
- Read latency: `rvalid` and `rdata` arrive in cycle t+1 for a grant in cycle t. Back-to-back reads give one result per cycle.
- Worst-case wait for a requesting port: 3×MAX_BURST cycles.
- Reset mid-burst: lock is lost and any pending `rvalid` is dropped; the requester reissues its read.
- Simultaneous owner release and new lock request: the new owner is chosen from the updated search order that same cycle.

## Structure
- Package `hack_mem_pkg`:
  - `AW`, `DW`, `N_REQ`=4
  - typedef `req_idx_t` (2b)
  - `MAX_BURST` default
- Sub-module `rr_pick4`, combinational:
  - in: `req[3:0]`, `start[1:0]`
  - out: one-hot `sel[3:0]`, `idx[1:0]`, `any`
- Address and data steering reuses the existing `mux4way16` on `idx` for `mem_wdata`. The address uses an AW-wide equivalent.
- All state lives in `mem_arbiter4`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `req`=4'b1111 → `gnt`=0 and `rvalid`=0. After release: `gnt`=4'b0001 first, then 0010, 0100, 1000, 0001.
- Read pipeline: port 2 reads addr 0x0010 while the memory model returns 0xBEEF → `gnt`=0100 at t; `rvalid`=0100 and `rdata`=0xBEEF at t+1. A write to the same port gives `mem_we`=1 and no `rvalid`.
- Lock cap: `req`=1111, `lock[1]`=1, `ptr`=1, MAX_BURST=4 → port 1 granted 4 consecutive cycles, then port 2. `ptr` ends at 2.
- Owner drop: port 3 locked, drops `req` after 2 grants → same cycle grants port 0 (`ptr` wraps past 3). `bcnt` returns to 0.
- Fairness: random `req`/`lock` for 10k cycles → `gnt` is one-hot or zero and only to requesters, and no requesting port waits more than 12 cycles. A scoreboard checks that every read returns `mem_rdata` to exactly the issuing port.
- Reset mid-burst: assert `rst_n`=0 in the cycle after a read grant → no `rvalid` the next cycle; arbitration restarts at port 0.

Source files
------------

// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory-port arbiter.
//   AW, DW     : default address / data widths (32K x 16 Hack RAM)
//   N_REQ      : number of requesters sharing the RAM port (fixed at 4)
//   MAX_BURST  : default cap on consecutive grants under lock
//   req_idx_t  : requester index type
//   idx_to_onehot : index -> one-hot grant vector helper
package hack_mem_pkg;

    localparam int unsigned AW        = 15;
    localparam int unsigned DW        = 16;
    localparam int unsigned N_REQ     = 4;
    localparam int unsigned MAX_BURST = 4;

    typedef logic [1:0] req_idx_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4way16.sv
// Four-way word multiplexer (Hack Mux4Way16), width-parameterised so the
// same block steers both the data word and the address.
//   a, b, c, d : inputs selected by sel = 0, 1, 2, 3
//   sel        : select
//   out        : selected word
module mux4way16 #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    input  logic [1:0]   sel,
    output logic [W-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational round-robin picker over four requesters.
//   req   : request vector
//   start : highest-priority index; search order is start, start+1, ... mod 4
//   sel   : one-hot selection, zero when no request
//   idx   : selected index; equals start when no request
//   any   : at least one request present
module rr_pick4
    import hack_mem_pkg::*;
(
    input  logic [3:0] req,
    input  req_idx_t   start,
    output logic [3:0] sel,
    output req_idx_t   idx,
    output logic       any
);

    req_idx_t cand;

    always_comb begin
        cand = start;
        idx  = start;
        any  = |req;
        // Walk the search order backwards so the earliest hit wins.
        for (int k = 3; k >= 0; k--) begin
            cand = start + req_idx_t'(k);
            if (req[cand]) begin
                idx = cand;
            end
        end
        sel = any ? idx_to_onehot(idx) : 4'b0000;
    end

endmodule

// File: rtl/mem_arbiter4.sv
// Four-port round-robin arbiter for the single Hack RAM port, with optional
// capped lock bursts and a one-cycle read-return pipeline.
//   clk, rst_n          : clock, synchronous active-low reset
//   req, lock, we       : per-port request, burst hint, write enable
//   addr_i, wdata_i     : packed per-port address / write data
//   gnt                 : combinational one-hot (or zero) grant
//   rvalid, rdata       : registered per-port read valid, read data
//   mem_addr/wdata/we   : memory command from the granted port
//   mem_rdata           : memory read data (one cycle after address)
module mem_arbiter4 #(
    parameter int unsigned AW        = hack_mem_pkg::AW,
    parameter int unsigned DW        = hack_mem_pkg::DW,
    parameter int unsigned MAX_BURST = hack_mem_pkg::MAX_BURST
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      req,
    input  logic [3:0]      lock,
    input  logic [3:0]      we,
    input  logic [4*AW-1:0] addr_i,
    input  logic [4*DW-1:0] wdata_i,
    output logic [3:0]      gnt,
    output logic [3:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_we,
    input  logic [DW-1:0]   mem_rdata
);

    import hack_mem_pkg::*;

    req_idx_t   ptr_q, ptr_d;
    req_idx_t   owner_q, owner_d;
    logic       owned_q, owned_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [3:0] rv_q, rv_d;

    logic [3:0] pick_sel;
    req_idx_t   pick_idx;
    logic       pick_any;

    logic       owner_hold;
    req_idx_t   g_idx;
    logic [3:0] gnt_raw;
    logic       g_any;
    logic [4:0] burst_next;

    rr_pick4 u_pick (
        .req   (req),
        .start (ptr_q),
        .sel   (pick_sel),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // A locked owner keeps the port only while it still requests.
    assign owner_hold = owned_q & req[owner_q];

    always_comb begin
        if (owner_hold) begin
            g_idx   = owner_q;
            gnt_raw = idx_to_onehot(owner_q);
        end else begin
            g_idx   = pick_idx;
            gnt_raw = pick_any ? pick_sel : 4'b0000;
        end
    end

    assign gnt    = rst_n ? gnt_raw : 4'b0000;
    assign g_any  = |gnt;
    assign mem_we = |(gnt & we);

    // With no request g_idx falls back to ptr, so the port shows ptr's inputs.
    mux4way16 #(
        .W (AW)
    ) u_addr_mux (
        .a   (addr_i[0*AW +: AW]),
        .b   (addr_i[1*AW +: AW]),
        .c   (addr_i[2*AW +: AW]),
        .d   (addr_i[3*AW +: AW]),
        .sel (g_idx),
        .out (mem_addr)
    );

    mux4way16 #(
        .W (DW)
    ) u_wdata_mux (
        .a   (wdata_i[0*DW +: DW]),
        .b   (wdata_i[1*DW +: DW]),
        .c   (wdata_i[2*DW +: DW]),
        .d   (wdata_i[3*DW +: DW]),
        .sel (g_idx),
        .out (mem_wdata)
    );

    // RAM output is already registered, so read data passes straight through.
    assign rvalid = rv_q;
    assign rdata  = mem_rdata;

    always_comb begin
        ptr_d   = ptr_q;
        owner_d = owner_q;
        owned_d = 1'b0;
        bcnt_d  = 4'd0;
        rv_d    = gnt & ~we;
        // A burst count only carries over when the owner itself is granted;
        // a dropped owner's count is discarded.
        burst_next = (owner_hold ? {1'b0, bcnt_q} : 5'd0) + 5'd1;
        if (g_any) begin
            if (lock[g_idx] && (32'(burst_next) < MAX_BURST)) begin
                owned_d = 1'b1;
                owner_d = g_idx;
                bcnt_d  = burst_next[3:0];
            end else begin
                ptr_d = g_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            owned_q <= 1'b0;
            bcnt_q  <= 4'd0;
            rv_q    <= 4'b0000;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            owned_q <= owned_d;
            bcnt_q  <= bcnt_d;
            rv_q    <= rv_d;
        end
    end

endmodule
